// File: rtl/pair_cover_acc_if.sv
// Beat/result stream bundle for the pair-cover accumulator.
interface pair_cover_acc_if #(
  parameter int NCH   = 4,
  parameter int W     = 16,
  parameter int BEATS = 2
);
  localparam int CW = $clog2(W * BEATS + 1);

  logic              in_valid;
  logic              in_ready;
  logic [NCH*W-1:0]  in_a;
  logic [NCH*W-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [NCH-1:0]    out_flag;
  logic [NCH*CW-1:0] out_miss;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_flag, out_miss
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_flag, out_miss
  );
endinterface

// File: rtl/pair_cover_acc.sv
// Per-channel uncovered-position accumulator over a multi-beat frame.
//
// state | meaning
// ACC   | accepting beats, accumulating miss counts
// HOLD  | frame result presented, waiting for out_ready
module pair_cover_acc #(
  parameter int NCH   = 4,
  parameter int W     = 16,
  parameter int BEATS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              mode,
  pair_cover_acc_if.slave   bus
);
  localparam int CW = $clog2(W * BEATS + 1);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] FULL_MISS = CW'(W * BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [NCH*CW-1:0] acc_q, acc_d;
  logic              mode_q, mode_d;
  logic [NCH-1:0]    flag_q, flag_d;
  logic [NCH*CW-1:0] miss_q, miss_d;

  logic [CW-1:0]     miss_beat [NCH];
  logic [NCH*CW-1:0] sum;
  logic              accept;
  logic              last;
  logic              eff_mode;

  // Per-channel popcount of positions where neither rail is set.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      miss_beat[c] = '0;
      for (int i = 0; i < W; i++) begin
        miss_beat[c] = miss_beat[c] + CW'(~(bus.in_a[c*W+i] | bus.in_b[c*W+i]));
      end
    end
  end

  // Running totals including the current beat, and the verdict they imply.
  always_comb begin
    sum    = '0;
    flag_d = '0;
    for (int c = 0; c < NCH; c++) begin
      sum[c*CW +: CW] = acc_q[c*CW +: CW] + miss_beat[c];
      flag_d[c] = eff_mode ? (sum[c*CW +: CW] < FULL_MISS)
                           : (sum[c*CW +: CW] == '0);
    end
  end

  // The first beat of a frame supplies the mode directly so BEATS==1 works.
  assign eff_mode = (beat_q == '0) ? mode : mode_q;
  assign accept   = (state_q == ST_ACC) && bus.in_valid && !clear;
  assign last     = (beat_q == LAST_BEAT);

  // Next-state and datapath update; clear only acts while accumulating.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    miss_d  = miss_q;
    case (state_q)
      ST_ACC: begin
        if (clear) begin
          beat_d = '0;
          acc_d  = '0;
        end else if (accept) begin
          mode_d = eff_mode;
          if (last) begin
            state_d = ST_HOLD;
            beat_d  = '0;
            acc_d   = '0;
            miss_d  = sum;
          end else begin
            beat_d = beat_q + BW'(1);
            acc_d  = sum;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State registers; the verdict is captured only when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      beat_q  <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      flag_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      miss_q  <= miss_d;
      if (accept && last) flag_q <= flag_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_flag  = flag_q;
  assign bus.out_miss  = miss_q;
endmodule

// File: tb/tb_pair_cover_acc.sv
// Directed bench for pair_cover_acc (NCH=4, W=16, BEATS=2).
module tb_pair_cover_acc;
  localparam int NCH   = 4;
  localparam int W     = 16;
  localparam int BEATS = 2;
  localparam int CW    = 6;

  logic clk;
  logic rst_n;
  logic clear;
  logic mode;
  int   n_checks;
  int   n_errors;

  pair_cover_acc_if #(.NCH(NCH), .W(W), .BEATS(BEATS)) bus ();

  pair_cover_acc #(.NCH(NCH), .W(W), .BEATS(BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .mode  (mode),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one clock; samples are taken #1 after the edge.
  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic m, input logic clr);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    mode         = m;
    clear        = clr;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] flag, input logic [23:0] miss);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_flag"},  64'(bus.out_flag), 64'(flag));
    check({tag, "_miss"},  64'(bus.out_miss), 64'(miss));
  endtask

  localparam logic [63:0] COV  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NONE = 64'h0;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    clear         = 1'b0;
    mode          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_flag",  64'(bus.out_flag),  64'd0);
    check("rst_miss",  64'(bus.out_miss),  64'd0);
    check("rst_ready", 64'(bus.in_ready),  64'd1);

    // ALL mode, fully covered frame
    beat(COV, NONE, 1'b0, 1'b0);
    check("all1_mid_valid", 64'(bus.out_valid), 64'd0);
    beat(COV, NONE, 1'b0, 1'b0);
    check_result("all1", 4'b1111, 24'h0);
    consume();
    check("all1_done", 64'(bus.out_valid), 64'd0);

    // ALL mode, channel 2 misses one position on beat 1
    beat(64'hFFFF_FFFE_FFFF_FFFF, NONE, 1'b0, 1'b0);
    beat(COV, NONE, 1'b0, 1'b0);
    check_result("all2", 4'b1011, {6'd0, 6'd1, 6'd0, 6'd0});
    consume();

    // ANY mode; mode flips to ALL on beat 2 and must be ignored
    beat(64'hFFFF_FFFF_0000_0000, NONE, 1'b1, 1'b0);
    beat(64'hFFFF_FFFF_0000_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    check_result("any", 4'b1110, {6'd0, 6'd0, 6'd31, 6'd32});

    // Backpressure with in_valid held high
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = NONE;
    bus.in_b     = NONE;
    mode         = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_ready", 64'(bus.in_ready),  64'd0);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_flag",  64'(bus.out_flag),  64'(4'b1110));
      check("bp_miss",  64'(bus.out_miss),  64'({6'd0, 6'd0, 6'd31, 6'd32}));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_drop_valid", 64'(bus.out_valid), 64'd0);
    check("bp_drop_ready", 64'(bus.in_ready),  64'd1);
    // in_valid still high with an uncovered beat: accepted on this edge
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_beat1_valid", 64'(bus.out_valid), 64'd0);
    beat(COV, NONE, 1'b1, 1'b0);
    check_result("bp", 4'b0000, {6'd16, 6'd16, 6'd16, 6'd16});
    consume();

    // Clear coincident with beat 1 drops it
    beat(NONE, NONE, 1'b0, 1'b1);
    check("clr_ready", 64'(bus.in_ready), 64'd1);
    beat(COV, NONE, 1'b0, 1'b0);
    check("clr_mid_valid", 64'(bus.out_valid), 64'd0);
    beat(COV, NONE, 1'b0, 1'b0);
    check_result("clr", 4'b1111, 24'h0);
    // Clear during HOLD must not discard the result
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_result("clr_hold", 4'b1111, 24'h0);
    consume();

    // Reset mid-frame
    beat(NONE, NONE, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rstmid_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_miss",  64'(bus.out_miss),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_ready", 64'(bus.in_ready), 64'd1);
    beat(COV, NONE, 1'b0, 1'b0);
    check("rstmid_mid_valid", 64'(bus.out_valid), 64'd0);
    beat(COV, NONE, 1'b0, 1'b0);
    check_result("rstmid", 4'b1111, 24'h0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pair_cover_acc.md
Name: pair_cover_acc

Overview:
- Parametrised, sequential successor to the flat pair-cover reduction logic.
- Checks NCH independent channels; each channel carries W bit-pairs (a,b) per beat, and a frame is BEATS beats long.
- Per channel, the block accumulates over the frame how many positions had neither bit set (uncovered) and returns a cover flag plus the miss count over a valid/ready stream.
- Sits between the operand staging registers and the result collector.

Parameters:
NCH, 4, number of independent channels
W, 16, bit-pairs per channel per beat
BEATS, 2, beats per frame (>=1)
CW, $clog2(W*BEATS+1), per-channel miss-count width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of partial frame
mode  in  1  0=ALL (every position covered), 1=ANY (at least one position covered); sampled on first beat of frame
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&in_ready
in_a  in  NCH*W  rail A, channel c at [c*W +: W]
in_b  in  NCH*W  rail B, same packing
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_flag  out  NCH  per-channel cover verdict
out_miss  out  NCH*CW  per-channel uncovered-position count, channel c at [c*CW +: CW]

Behaviour:
- Reset (async assert, sync release): state=ACC, beat_cnt=0, acc_miss=0, mode_q=0, out_valid=0, out_flag=0, out_miss=0, in_ready=1.
- States: ACC (accepting beats), HOLD (result presented). in_ready = (state==ACC).
- Per beat, per channel: miss_beat = popcount(~(a|b)) over W positions. Accept: acc_miss[c] += miss_beat[c]. Width CW holds the maximum W*BEATS exactly; no saturation or wrap is possible.
- mode_q is latched on the beat with beat_cnt==0. mode changes mid-frame are ignored.
- Last beat (beat_cnt==BEATS-1, accepted): the next cycle has state=HOLD, out_valid=1, and out_miss = acc_miss including that beat. beat_cnt and acc_miss clear in the same edge. Latency: one cycle from the last-beat handshake to out_valid.
- out_flag[c]: in ALL mode, 1 iff out_miss[c]==0. In ANY mode, 1 iff out_miss[c] < W*BEATS.
- HOLD: out_flag and out_miss are stable while out_valid&!out_ready. On out_ready the next cycle has out_valid=0 and state=ACC. No same-cycle bypass: a new beat cannot be accepted in the cycle the result is consumed.
- clear in ACC: beat_cnt and acc_miss go to 0. A beat presented in the same cycle is dropped (clear wins; in_ready stays 1 that cycle, but the beat is discarded).
- clear in HOLD: no effect. The presented result is never discarded.
- BEATS==1: every accepted beat is a complete frame.
- Async reset mid-frame or mid-HOLD discards everything and returns to the reset values.
- Inputs are sampled only on handshake. in_a and in_b are don't-care otherwise.

Test Plan:
(NCH=4, W=16, BEATS=2 unless noted)
1. Reset check: rst_n low, then released -> out_valid=0, out_flag=0, out_miss=0, in_ready=1.
2. ALL mode, all channels a=16'hFFFF, b=0 on both beats -> one cycle after beat 2: out_valid=1, out_flag=4'b1111, all out_miss=0.
3. ALL mode, channel 2 beat 1 a=16'hFFFE b=16'h0000, everything else covered -> out_flag=4'b1011, out_miss[2]=1, others 0.
4. ANY mode:
   - Channel 0 a=b=0 on both beats -> flag0=0, miss0=32.
   - Channel 1 b=16'h0001 on beat 2 only -> flag1=1, miss1=31.
5. Backpressure: result presented with out_ready=0 for 3 cycles, in_valid held high -> in_ready=0 throughout, outputs unchanged. Then out_ready=1 -> out_valid drops the next cycle, and the next beat is accepted the cycle after.
6. Flush and reset:
   - clear together with beat 1 of a frame -> beat dropped; the following two beats form the frame and the miss counts reflect only them.
   - Separately, rst_n pulsed low after beat 1 -> no result, counters 0.
